// File: rtl/prbs7_pkg.sv
// Shared PRBS7 (x^7+x^6+1) definitions used by the word generator and the checker.
package prbs7_pkg;

   localparam int unsigned PN       = 7;
   localparam int unsigned MAX_W    = 64;
   localparam int unsigned DEF_TAP1 = 6;
   localparam int unsigned DEF_TAP2 = 5;

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } chk_state_e;

   // Word produced by `width` LFSR steps from `state`; newest bit in LSB, upper bits zero.
   function automatic logic [MAX_W-1:0] prbs7_next_word(input logic [PN-1:0] state,
                                                         input int unsigned width,
                                                         input int unsigned tap1,
                                                         input int unsigned tap2);
      logic [PN-1:0]    s;
      logic [MAX_W-1:0] w;
      logic             nb;
      s = state;
      w = '0;
      for (int unsigned i = 0; i < MAX_W; i++) begin
         if (i < width) begin
            nb = s[3'(tap1)] ^ s[3'(tap2)];
            s  = {s[PN-2:0], nb};
            w  = {w[MAX_W-2:0], nb};
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/prbs7_checker_if.sv
// Word stream into the PRBS7 checker and its error/lock reporting.
interface prbs7_checker_if #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned CNT_W = 32
);
   localparam int unsigned EB_W = $clog2(WIDTH + 1);

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             cnt_clr;
   logic             locked;
   logic             err_valid;
   logic             err_word;
   logic [EB_W-1:0]  err_bits;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] word_cnt;

   modport master (
      output in_valid, in_data, cnt_clr,
      input  locked, err_valid, err_word, err_bits, err_cnt, word_cnt
   );

   modport slave (
      input  in_valid, in_data, cnt_clr,
      output locked, err_valid, err_word, err_bits, err_cnt, word_cnt
   );
endinterface

// File: rtl/prbs_popcount.sv
// Population count of a WIDTH-bit vector: combinational count plus a registered copy.
module prbs_popcount #(
   parameter  int unsigned WIDTH = 24,
   localparam int unsigned CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vld,
   input  logic [WIDTH-1:0] vec,
   output logic [CW-1:0]    cnt_c,
   output logic [CW-1:0]    cnt,
   output logic             cnt_vld
);

   always_comb begin
      cnt_c = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         cnt_c = cnt_c + CW'(vec[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         cnt_vld <= 1'b0;
      end else begin
         cnt_vld <= vld;
         if (vld) cnt <= cnt_c;
      end
   end

endmodule

// File: rtl/prbs7_checker.sv
// PRBS7 receive checker: self-synchronising hunt/lock FSM, local LFSR,
// two-stage error pipeline and saturating error/word counters.
module prbs7_checker
   import prbs7_pkg::*;
#(
   parameter int unsigned WIDTH      = 24,
   parameter int unsigned TAP1       = DEF_TAP1,
   parameter int unsigned TAP2       = DEF_TAP2,
   parameter int unsigned LOCK_CNT   = 4,
   parameter int unsigned UNLOCK_CNT = 4,
   parameter int unsigned BAD_BITS   = 2,
   parameter int unsigned CNT_W      = 32
) (
   input logic            clk,
   input logic            rst_n,
   prbs7_checker_if.slave bus
);

   localparam int unsigned EB_W  = $clog2(WIDTH + 1);
   localparam int unsigned RUN_W = 4;

   chk_state_e       state;
   logic             locked_q;
   logic [PN-1:0]    lfsr;
   logic [PN-1:0]    prev7;
   logic [RUN_W-1:0] good_run;
   logic [RUN_W-1:0] bad_run;

   logic [MAX_W-1:0] hunt_word_c;
   logic [MAX_W-1:0] lock_word_c;
   logic [WIDTH-1:0] hunt_exp_c;
   logic [WIDTH-1:0] lock_exp_c;
   logic [WIDTH-1:0] s0_xor_c;
   logic [EB_W-1:0]  s0_bits_c;
   logic             hunt_clean_c;
   logic             s0_bad_c;
   logic             unused_hi_c;

   logic             x_valid;
   logic [WIDTH-1:0] x_vec;
   logic [EB_W-1:0]  pc_cnt_c;
   logic [EB_W-1:0]  err_bits_q;
   logic             err_valid_q;
   logic             err_word_q;
   logic [CNT_W-1:0] err_cnt_q;
   logic [CNT_W-1:0] word_cnt_q;
   logic [CNT_W:0]   err_sum_c;

   // Expected words: continuation of the previous word in HUNT, of the local LFSR in LOCKED
   assign hunt_word_c  = prbs7_next_word(prev7, WIDTH, TAP1, TAP2);
   assign lock_word_c  = prbs7_next_word(lfsr, WIDTH, TAP1, TAP2);
   assign hunt_exp_c   = hunt_word_c[WIDTH-1:0];
   assign lock_exp_c   = lock_word_c[WIDTH-1:0];
   assign unused_hi_c  = ^{hunt_word_c[MAX_W-1:WIDTH], lock_word_c[MAX_W-1:WIDTH]};

   // prev7 starts at zero, whose continuation is all-zero and thus never clean
   assign hunt_clean_c = (bus.in_data == hunt_exp_c) && (bus.in_data != '0);
   assign s0_xor_c     = bus.in_data ^ lock_exp_c;

   always_comb begin
      s0_bits_c = '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         s0_bits_c = s0_bits_c + EB_W'(s0_xor_c[i]);
      end
   end

   assign s0_bad_c = s0_bits_c > EB_W'(BAD_BITS);

   // Hunt/lock FSM, run counters and local LFSR
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= HUNT;
         locked_q <= 1'b0;
         lfsr     <= '0;
         prev7    <= '0;
         good_run <= '0;
         bad_run  <= '0;
      end else if (bus.in_valid) begin
         case (state)
            HUNT: begin
               prev7 <= bus.in_data[PN-1:0];
               if (hunt_clean_c) begin
                  if (good_run == RUN_W'(LOCK_CNT - 1)) begin
                     state    <= LOCKED;
                     locked_q <= 1'b1;
                     lfsr     <= bus.in_data[PN-1:0];
                     good_run <= '0;
                     bad_run  <= '0;
                  end else begin
                     good_run <= good_run + RUN_W'(1);
                  end
               end else begin
                  good_run <= '0;
               end
            end
            LOCKED: begin
               lfsr <= lock_exp_c[PN-1:0];
               if (s0_bad_c) begin
                  if (bad_run == RUN_W'(UNLOCK_CNT - 1)) begin
                     state    <= HUNT;
                     locked_q <= 1'b0;
                     prev7    <= bus.in_data[PN-1:0];
                     good_run <= '0;
                     bad_run  <= '0;
                  end else begin
                     bad_run <= bad_run + RUN_W'(1);
                  end
               end else begin
                  bad_run <= '0;
               end
            end
         endcase
      end
   end

   // Stage 1: error vector of each word accepted while LOCKED
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         x_valid <= 1'b0;
         x_vec   <= '0;
      end else begin
         x_valid <= bus.in_valid && (state == LOCKED);
         if (bus.in_valid && (state == LOCKED)) x_vec <= s0_xor_c;
      end
   end

   // Stage 2: registered bit-error count
   prbs_popcount #(.WIDTH(WIDTH)) u_popcount (
      .clk     (clk),
      .rst_n   (rst_n),
      .vld     (x_valid),
      .vec     (x_vec),
      .cnt_c   (pc_cnt_c),
      .cnt     (err_bits_q),
      .cnt_vld (err_valid_q)
   );

   assign err_sum_c = {1'b0, err_cnt_q} + (CNT_W + 1)'(pc_cnt_c);

   // Counters move on the same edge that launches err_valid; clear has priority
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_word_q <= 1'b0;
         err_cnt_q  <= '0;
         word_cnt_q <= '0;
      end else begin
         if (x_valid) err_word_q <= (pc_cnt_c != '0);
         if (bus.cnt_clr) begin
            err_cnt_q  <= '0;
            word_cnt_q <= '0;
         end else if (x_valid) begin
            err_cnt_q  <= err_sum_c[CNT_W] ? '1 : err_sum_c[CNT_W-1:0];
            word_cnt_q <= (&word_cnt_q) ? word_cnt_q : word_cnt_q + CNT_W'(1);
         end
      end
   end

   assign bus.locked    = locked_q;
   assign bus.err_valid = err_valid_q;
   assign bus.err_bits  = err_bits_q;
   assign bus.err_word  = err_word_q;
   assign bus.err_cnt   = err_cnt_q;
   assign bus.word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_prbs7_checker.sv
// Bench for prbs7_checker: directed scenarios plus random traffic against a bit-level reference model.
module tb_prbs7_checker;

   localparam int unsigned W          = 24;
   localparam int unsigned LOCK_CNT   = 4;
   localparam int unsigned UNLOCK_CNT = 4;
   localparam int unsigned BAD_BITS   = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         cnt_clr;
   logic [W-1:0] in_data;

   always #5 clk = ~clk;

   prbs7_checker_if #(.WIDTH(W), .CNT_W(32)) b32 ();
   prbs7_checker_if #(.WIDTH(W), .CNT_W(8))  b8 ();

   assign b32.in_valid = in_valid;
   assign b32.in_data  = in_data;
   assign b32.cnt_clr  = cnt_clr;
   assign b8.in_valid  = in_valid;
   assign b8.in_data   = in_data;
   assign b8.cnt_clr   = cnt_clr;

   prbs7_checker #(.WIDTH(W), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(b32));
   prbs7_checker #(.WIDTH(W), .CNT_W(8))  dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));

   int total;
   int bad;

   // Reference model state
   typedef struct { int due; int bits; } ev_t;
   ev_t        evq[$];
   int         cyc;
   bit         m_locked;
   bit         m_have_prev;
   logic [6:0] m_prev;
   logic [6:0] m_lfsr;
   int         m_good;
   int         m_bad;
   longint     m_ecnt32, m_wcnt32, m_ecnt8, m_wcnt8;
   bit         exp_ev;
   int         exp_bits;
   logic [6:0] gen_state;

   // PRBS continuation from a 7-bit window, built bit by bit: b[n] = b[n-7] ^ b[n-6]
   function automatic logic [W-1:0] prbs_from(input logic [6:0] s);
      bit           h[$];
      bit           nb;
      logic [W-1:0] w;
      w = '0;
      for (int k = 6; k >= 0; k--) h.push_back(s[k]);
      for (int i = 0; i < int'(W); i++) begin
         nb = h[h.size()-7] ^ h[h.size()-6];
         h.push_back(nb);
         w = {w[W-2:0], nb};
      end
      return w;
   endfunction

   function automatic logic [W-1:0] gen_next();
      logic [W-1:0] w;
      w = prbs_from(gen_state);
      gen_state = w[6:0];
      return w;
   endfunction

   function automatic longint sat_add(input longint a, input longint b, input longint maxv);
      return (a + b > maxv) ? maxv : a + b;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   task automatic model_edge(input bit v, input logic [W-1:0] d, input bit clr);
      logic [W-1:0] e;
      int           nb;
      bit           clean;
      cyc++;
      exp_ev = 1'b0;
      if (!rst_n) begin
         evq.delete();
         m_locked = 0; m_have_prev = 0; m_prev = '0; m_lfsr = '0; m_good = 0; m_bad = 0;
         m_ecnt32 = 0; m_wcnt32 = 0; m_ecnt8 = 0; m_wcnt8 = 0;
         return;
      end
      if (evq.size() > 0 && evq[0].due == cyc) begin
         exp_ev   = 1'b1;
         exp_bits = evq[0].bits;
         void'(evq.pop_front());
         m_ecnt32 = sat_add(m_ecnt32, exp_bits, 64'hFFFF_FFFF);
         m_wcnt32 = sat_add(m_wcnt32, 1, 64'hFFFF_FFFF);
         m_ecnt8  = sat_add(m_ecnt8, exp_bits, 255);
         m_wcnt8  = sat_add(m_wcnt8, 1, 255);
      end
      if (clr) begin
         m_ecnt32 = 0; m_wcnt32 = 0; m_ecnt8 = 0; m_wcnt8 = 0;
      end
      if (v) begin
         if (m_locked) begin
            e  = prbs_from(m_lfsr);
            nb = $countones(d ^ e);
            evq.push_back('{cyc + 1, nb});
            m_lfsr = e[6:0];
            if (nb > int'(BAD_BITS)) begin
               m_bad++;
               if (m_bad == int'(UNLOCK_CNT)) begin
                  m_locked = 0; m_prev = d[6:0]; m_have_prev = 1; m_good = 0; m_bad = 0;
               end
            end else m_bad = 0;
         end else begin
            clean = m_have_prev && (d == prbs_from(m_prev)) && (d != '0);
            m_prev = d[6:0];
            m_have_prev = 1;
            if (clean) begin
               m_good++;
               if (m_good == int'(LOCK_CNT)) begin
                  m_locked = 1; m_lfsr = d[6:0]; m_good = 0; m_bad = 0;
               end
            end else m_good = 0;
         end
      end
   endtask

   task automatic step(input bit v, input logic [W-1:0] d, input bit clr);
      in_valid = v;
      in_data  = d;
      cnt_clr  = clr;
      @(posedge clk);
      model_edge(v, d, clr);
      #1;
      chk("locked", b32.locked, m_locked);
      chk("locked_c8", b8.locked, m_locked);
      chk("err_valid", b32.err_valid, exp_ev);
      chk("err_valid_c8", b8.err_valid, exp_ev);
      if (exp_ev) begin
         chk("err_bits", b32.err_bits, exp_bits);
         chk("err_word", b32.err_word, exp_bits != 0);
      end
      chk("err_cnt", b32.err_cnt, m_ecnt32);
      chk("word_cnt", b32.word_cnt, m_wcnt32);
      chk("err_cnt_c8", b8.err_cnt, m_ecnt8);
      chk("word_cnt_c8", b8.word_cnt, m_wcnt8);
   endtask

   task automatic send(input bit v, input logic [W-1:0] mask, input bit clr);
      logic [W-1:0] d;
      if (v) d = gen_next() ^ mask;
      else   d = W'($urandom);
      step(v, d, clr);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) step(1'b0, '0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      int  accepted;
      bit  seen;
      int  r;
      logic [W-1:0] mask;

      total = 0; bad = 0; cyc = 0;
      in_valid = 0; in_data = '0; cnt_clr = 0; rst_n = 0;
      gen_state = 7'h7F;

      // Reset state
      do_reset(3);
      chk("rst_locked", b32.locked, 0);
      chk("rst_err_cnt", b32.err_cnt, 0);

      // Clean stream: lock after 1 seed + 4 clean words
      repeat (4) send(1'b1, '0, 1'b0);
      chk("pre_lock", b32.locked, 0);
      send(1'b1, '0, 1'b0);
      chk("lock_at_5", b32.locked, 1);
      repeat (20) send(1'b1, '0, 1'b0);
      repeat (2) send(1'b0, '0, 1'b0);
      chk("clean_err_cnt", b32.err_cnt, 0);
      chk("clean_word_cnt", b32.word_cnt, 20);

      // Single bit flip: one error, no multiplication
      send(1'b0, '0, 1'b1);
      send(1'b1, 24'h000001, 1'b0);
      repeat (10) send(1'b1, '0, 1'b0);
      repeat (2) send(1'b0, '0, 1'b0);
      chk("flip_err_cnt", b32.err_cnt, 1);
      chk("flip_locked", b32.locked, 1);

      // Four fully inverted words: unlock, then relock 5 clean words later
      send(1'b0, '0, 1'b1);
      repeat (4) send(1'b1, '1, 1'b0);
      chk("inv_unlocked", b32.locked, 0);
      repeat (4) send(1'b1, '0, 1'b0);
      chk("inv_pre_relock", b32.locked, 0);
      send(1'b1, '0, 1'b0);
      chk("inv_relock", b32.locked, 1);
      repeat (2) send(1'b0, '0, 1'b0);
      chk("inv_err_cnt", b32.err_cnt, 96);

      // Reset with words in flight: pipeline flushed
      repeat (3) send(1'b1, '0, 1'b0);
      do_reset(2);
      repeat (2) send(1'b0, '0, 1'b0);

      // All-zero input never locks
      repeat (100) step(1'b1, '0, 1'b0);
      chk("zero_locked", b32.locked, 0);
      chk("zero_word_cnt", b32.word_cnt, 0);

      // Random in_valid on a clean stream
      do_reset(2);
      gen_state = 7'h35;
      accepted = 0; seen = 0;
      repeat (150) begin
         r = int'($urandom_range(0, 1));
         send(r[0], '0, 1'b0);
         if (r[0]) accepted++;
         if (!seen && b32.locked === 1'b1) begin
            seen = 1;
            chk("rv_lock_words", accepted, 5);
         end
      end
      chk("rv_lock_seen", seen, 1);
      repeat (2) send(1'b0, '0, 1'b0);
      chk("rv_err_cnt", b32.err_cnt, 0);

      // Saturation in the 8-bit build, then clear coincident with a launched word
      do_reset(2);
      gen_state = 7'h01;
      repeat (5) send(1'b1, '0, 1'b0);
      for (int i = 0; i < 60; i++) send(1'b1, (i % 2 == 0) ? 24'h000FFF : 24'h0, 1'b0);
      repeat (2) send(1'b0, '0, 1'b0);
      chk("sat_err_cnt_c8", b8.err_cnt, 255);
      chk("sat_err_cnt", b32.err_cnt, 360);
      send(1'b1, 24'h000FFF, 1'b0);
      send(1'b0, '0, 1'b1);
      chk("clr_err_cnt_c8", b8.err_cnt, 0);
      chk("clr_err_cnt", b32.err_cnt, 0);
      chk("clr_word_cnt", b32.word_cnt, 0);
      repeat (2) send(1'b0, '0, 1'b0);

      // Random traffic with random errors and clears
      do_reset(2);
      gen_state = 7'h5A;
      repeat (400) begin
         r = int'($urandom_range(0, 99));
         if (r < 4)       mask = W'(1) << $urandom_range(0, W - 1);
         else if (r < 7)  mask = W'($urandom);
         else if (r < 10) mask = '1;
         else             mask = '0;
         send($urandom_range(0, 3) != 0, mask, $urandom_range(0, 49) == 0);
      end
      repeat (3) send(1'b0, '0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
